// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and constant helpers for the sequential BCD converter
package bcd_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_digit_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock shift-and-add-3 binary to BCD converter with saturation on overflow
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_p,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);
   localparam int AW = 4 * DIGITS;
   localparam int CW = BIN_W > 1 ? clog2(BIN_W) : 1;
   localparam logic [63:0] MAX = pow10(DIGITS) - 64'd1;
   state_t           state;
   logic [BIN_W-1:0] sr;
   logic [AW-1:0]    acc, adj, acc_nx;
   logic [CW-1:0]    cnt;
   logic             ovf_n;
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
   end
   assign acc_nx = {adj[AW-2:0], sr[BIN_W-1]};
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= '0;
         ovf   <= 1'b0;
         sr    <= '0;
         acc   <= '0;
         cnt   <= '0;
         ovf_n <= 1'b0;
      end else if (state == SHIFT) begin
         acc <= acc_nx;
         sr  <= sr << 1;
         cnt <= cnt - CW'(1);
         if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bcd   <= ovf_n ? {DIGITS{4'h9}} : acc_nx;
            ovf   <= ovf_n;
         end
      end else begin
         done <= 1'b0;
         // DONE accepts start exactly like IDLE so a held start converts back-to-back
         if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            sr    <= bin;
            acc   <= '0;
            cnt   <= CW'(BIN_W - 1);
            ovf_n <= 64'(bin) > MAX;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule
